// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the extended synchronous FIFO.
//   cnt_width : width of an occupancy counter able to hold 0..depth
//   ptr_next  : pointer increment with explicit wrap at depth-1,
//               so non-power-of-two depths work without rollover tricks
package sync_fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_ext.
//   clk    : write clock
//   we     : write enable, wdata stored at waddr on rising edge
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : asynchronous read data (mem[raddr])
// The array has no reset; contents survive reset and flush.
module sync_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int DWIDTH = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow, synchronous flush and optional
// first-word-fall-through output.
//   clk          : clock
//   reset        : asynchronous active-high reset
//   flush        : synchronous clear of pointers, count, error flags
//   wr_en, din   : write request and data
//   rd_en        : read request (standard) / pop request (FWFT)
//   dout         : read data (registered in standard mode, head word in FWFT)
//   empty, full  : count == 0 / count == DEPTH
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : occupancy 0..DEPTH
//   overflow     : sticky, a write was dropped
//   underflow    : sticky, a read was rejected
module sync_fifo_ext
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int DWIDTH   = 16,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [DWIDTH-1:0]           din,
  input  logic                        rd_en,
  output logic [DWIDTH-1:0]           dout,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [PW-1:0]     wptr, rptr;
  logic [DWIDTH-1:0] rdata, dout_r;
  logic              wr_acc, rd_acc;

  // Flags come only from the count register, never from the request inputs.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A read frees a slot in the same edge, so a full FIFO still accepts a
  // write when a read is accepted alongside it.
  assign rd_acc = rd_en & ~empty & ~flush;
  assign wr_acc = wr_en & (~full | rd_acc) & ~flush;

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .DWIDTH(DWIDTH),
    .AW    (PW)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wptr),
    .wdata(din),
    .raddr(rptr),
    .rdata(rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      dout_r    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      dout_r    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= PW'(ptr_next(32'(wptr), DEPTH));
      if (rd_acc) begin
        rptr   <= PW'(ptr_next(32'(rptr), DEPTH));
        dout_r <= rdata;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (rd_en && empty)   underflow <= 1'b1;
    end
  end

  // FWFT presents the head word directly; standard mode uses the register.
  assign dout = (FWFT != 0) ? rdata : dout_r;

endmodule

// File: tb/tb_sync_fifo_ext.sv
module tb_sync_fifo_ext;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DEPTH=4 standard mode, AF_LEVEL=3, AE_LEVEL=1
  logic        d4_fl = 0, d4_wr = 0, d4_rd = 0;
  logic [15:0] d4_din = '0, d4_dout;
  logic        d4_empty, d4_full, d4_af, d4_ae, d4_ov, d4_un;
  logic [2:0]  d4_cnt;

  // DEPTH=5 standard mode
  logic        d5_fl = 0, d5_wr = 0, d5_rd = 0;
  logic [15:0] d5_din = '0, d5_dout;
  logic        d5_empty, d5_full, d5_af, d5_ae, d5_ov, d5_un;
  logic [2:0]  d5_cnt;

  // DEPTH=4 FWFT
  logic        fw_fl = 0, fw_wr = 0, fw_rd = 0;
  logic [15:0] fw_din = '0, fw_dout;
  logic        fw_empty, fw_full, fw_af, fw_ae, fw_ov, fw_un;
  logic [2:0]  fw_cnt;

  sync_fifo_ext #(.DEPTH(4), .DWIDTH(16), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_d4 (
    .clk(clk), .reset(reset), .flush(d4_fl), .wr_en(d4_wr), .din(d4_din),
    .rd_en(d4_rd), .dout(d4_dout), .empty(d4_empty), .full(d4_full),
    .almost_full(d4_af), .almost_empty(d4_ae), .count(d4_cnt),
    .overflow(d4_ov), .underflow(d4_un));

  sync_fifo_ext #(.DEPTH(5), .DWIDTH(16), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_d5 (
    .clk(clk), .reset(reset), .flush(d5_fl), .wr_en(d5_wr), .din(d5_din),
    .rd_en(d5_rd), .dout(d5_dout), .empty(d5_empty), .full(d5_full),
    .almost_full(d5_af), .almost_empty(d5_ae), .count(d5_cnt),
    .overflow(d5_ov), .underflow(d5_un));

  sync_fifo_ext #(.DEPTH(4), .DWIDTH(16), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_fw (
    .clk(clk), .reset(reset), .flush(fw_fl), .wr_en(fw_wr), .din(fw_din),
    .rd_en(fw_rd), .dout(fw_dout), .empty(fw_empty), .full(fw_full),
    .almost_full(fw_af), .almost_empty(fw_ae), .count(fw_cnt),
    .overflow(fw_ov), .underflow(fw_un));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q5[$];

  task automatic d5_op(input logic wr, input logic rd, input logic [15:0] data);
    logic        ra, wa;
    logic [15:0] exp;
    exp = '0;
    ra = rd && (q5.size() > 0);
    wa = wr && ((q5.size() < 5) || ra);
    if (ra) exp = q5.pop_front();
    if (wa) q5.push_back(data);
    d5_wr = wr; d5_rd = rd; d5_din = data;
    tick();
    if (ra) chk("d5_dout", 32'(d5_dout), 32'(exp));
    chk("d5_count", 32'(d5_cnt), 32'(q5.size()));
  endtask

  initial begin
    #2;
    chk("rst_empty", 32'(d4_empty), 32'd1);
    chk("rst_full",  32'(d4_full),  32'd0);
    chk("rst_count", 32'(d4_cnt),   32'd0);
    chk("rst_ae",    32'(d4_ae),    32'd1);
    chk("rst_af",    32'(d4_af),    32'd0);
    chk("rst_ov",    32'(d4_ov),    32'd0);
    chk("rst_un",    32'(d4_un),    32'd0);
    chk("rst_dout",  32'(d4_dout),  32'd0);
    #10 reset = 1'b0;

    // fill DEPTH=4
    for (int k = 0; k < 4; k++) begin
      d4_wr = 1; d4_din = 16'hA1 + 16'(k);
      tick();
      chk("fill_count", 32'(d4_cnt), 32'(k + 1));
      if (k == 0) chk("fill_ae1", 32'(d4_ae), 32'd1);
      if (k == 1) begin
        chk("fill_ae2", 32'(d4_ae), 32'd0);
        chk("fill_af2", 32'(d4_af), 32'd0);
      end
      if (k == 2) chk("fill_af3", 32'(d4_af), 32'd1);
    end
    chk("full", 32'(d4_full), 32'd1);
    d4_din = 16'hA5;
    tick();
    chk("ovf_flag",  32'(d4_ov),  32'd1);
    chk("ovf_count", 32'(d4_cnt), 32'd4);

    // drain
    d4_wr = 0; d4_rd = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_dout", 32'(d4_dout), 32'(16'hA1 + 16'(k)));
    end
    chk("drain_empty", 32'(d4_empty), 32'd1);
    tick();
    chk("unf_flag", 32'(d4_un),   32'd1);
    chk("unf_dout", 32'(d4_dout), 32'hA4);
    d4_rd = 0;

    d4_fl = 1;
    tick();
    d4_fl = 0;
    chk("flush_ov",   32'(d4_ov),   32'd0);
    chk("flush_un",   32'(d4_un),   32'd0);
    chk("flush_cnt",  32'(d4_cnt),  32'd0);
    chk("flush_dout", 32'(d4_dout), 32'd0);

    // simultaneous read/write while full
    d4_wr = 1;
    for (int k = 0; k < 4; k++) begin
      d4_din = 16'hB1 + 16'(k);
      tick();
    end
    d4_rd = 1; d4_din = 16'hC1;
    tick();
    chk("rw_full_cnt",  32'(d4_cnt),  32'd4);
    chk("rw_full_ov",   32'(d4_ov),   32'd0);
    chk("rw_full_dout", 32'(d4_dout), 32'hB1);
    chk("rw_full_full", 32'(d4_full), 32'd1);
    d4_wr = 0;
    tick();
    chk("rd_b2", 32'(d4_dout), 32'hB2);
    chk("cnt3",  32'(d4_cnt),  32'd3);

    // flush beats a concurrent write
    d4_rd = 0; d4_fl = 1; d4_wr = 1; d4_din = 16'hDD;
    tick();
    d4_fl = 0;
    chk("flw_cnt",   32'(d4_cnt),   32'd0);
    chk("flw_empty", 32'(d4_empty), 32'd1);
    chk("flw_ov",    32'(d4_ov),    32'd0);
    chk("flw_un",    32'(d4_un),    32'd0);

    // read+write while empty
    d4_wr = 1; d4_rd = 1; d4_din = 16'hD1;
    tick();
    chk("rw_empty_cnt",  32'(d4_cnt),  32'd1);
    chk("rw_empty_un",   32'(d4_un),   32'd1);
    chk("rw_empty_dout", 32'(d4_dout), 32'd0);
    d4_wr = 0;
    tick();
    chk("rd_d1",    32'(d4_dout),  32'hD1);
    chk("rd_empty", 32'(d4_empty), 32'd1);
    d4_rd = 0;

    // DEPTH=5: 12 words through, two pointer wraps
    for (int k = 0; k < 5; k++) d5_op(1, 0, 16'h50 + 16'(k));
    chk("d5_full", 32'(d5_full), 32'd1);
    d5_op(1, 0, 16'h5F);
    chk("d5_ov", 32'(d5_ov), 32'd1);
    for (int k = 0; k < 3; k++) d5_op(0, 1, 16'h0);
    for (int k = 0; k < 3; k++) d5_op(1, 0, 16'h60 + 16'(k));
    d5_op(1, 1, 16'h70);
    for (int k = 0; k < 5; k++) d5_op(0, 1, 16'h0);
    for (int k = 0; k < 3; k++) d5_op(1, 0, 16'h80 + 16'(k));
    for (int k = 0; k < 3; k++) d5_op(0, 1, 16'h0);
    chk("d5_empty", 32'(d5_empty), 32'd1);
    d5_wr = 0; d5_rd = 0;

    // FWFT
    fw_wr = 1; fw_din = 16'h55;
    tick();
    chk("fw_empty0", 32'(fw_empty), 32'd0);
    chk("fw_dout55", 32'(fw_dout),  32'h55);
    fw_din = 16'h66;
    tick();
    chk("fw_cnt2",   32'(fw_cnt),   32'd2);
    chk("fw_hold55", 32'(fw_dout),  32'h55);
    fw_wr = 0; fw_rd = 1;
    tick();
    chk("fw_dout66", 32'(fw_dout), 32'h66);
    chk("fw_cnt1",   32'(fw_cnt),  32'd1);
    tick();
    chk("fw_empty1", 32'(fw_empty), 32'd1);
    fw_rd = 0;

    // asynchronous reset mid-burst
    d4_wr = 1; d4_din = 16'hE0;
    tick();
    tick();
    #3 reset = 1'b1;
    #1;
    chk("arst_cnt",   32'(d4_cnt),   32'd0);
    chk("arst_empty", 32'(d4_empty), 32'd1);
    chk("arst_dout",  32'(d4_dout),  32'd0);
    chk("arst_un",    32'(d4_un),    32'd0);
    d4_wr = 0;
    #2 reset = 1'b0;
    d4_wr = 1; d4_din = 16'hE1;
    tick();
    chk("post_cnt", 32'(d4_cnt), 32'd1);
    d4_wr = 0; d4_rd = 1;
    tick();
    chk("post_dout", 32'(d4_dout), 32'hE1);
    d4_rd = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised synchronous FIFO that succeeds the basic FIFO in the shared hardware library. It adds full-depth occupancy, an occupancy count, and programmable almost-full/almost-empty flags. It also adds sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) output mode. It is a single-clock buffer between producer and consumer stages within one clock domain.

## Interface
- DEPTH, 8 — number of storage words; any integer ≥ 2, not restricted to powers of two
- DWIDTH, 16 — data width in bits
- AF_LEVEL, DEPTH-1 — almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 1 — almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1
- FWFT, 0 — 0: registered read (standard mode); 1: first-word-fall-through
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of FIFO contents and error flags
- wr_en  in  1  write request
- din  in  DWIDTH  write data
- rd_en  in  1  read request (standard mode) / pop request (FWFT)
- dout  out  DWIDTH  read data
- empty  out  1  no word available to read
- full  out  1  DEPTH words stored
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was rejected

## Operation
- State: write pointer, read pointer (each $clog2(DEPTH) bits), count register, dout register (standard mode), overflow and underflow flags.
- Pointers wrap explicitly from DEPTH-1 to 0; no reliance on power-of-two rollover.
- All DEPTH entries are usable.
- full = (count == DEPTH); empty = (count == 0); almost flags decode combinationally from the registered count.
- Write accepted = wr_en & (!full | rd_accepted). Data is stored at wptr and wptr advances.
- Read accepted = rd_en & !empty.
- count: +1 on write only, −1 on read only, unchanged when both or neither are accepted.
- Write while full with no accepted read: data dropped, pointers unchanged, overflow ← 1.
- Read while empty: ignored, dout unchanged, underflow ← 1. A simultaneous write while empty is still accepted.
- Standard mode (FWFT=0):
  - On an accepted read, dout ← mem[rptr] at the edge.
  - dout holds its value at all other times.
- FWFT mode (FWFT=1):
  - dout = mem[rptr] combinationally whenever !empty.
  - An accepted rd_en pops the head word; the next word appears after that edge.
  - While empty, dout is undefined.
- flush:
  - Priority over wr_en and rd_en in the same cycle.
  - Next state: wptr = rptr = count = 0, overflow = underflow = 0, dout = 0 in standard mode.
  - Memory contents are not cleared.
- overflow/underflow clear only on reset or flush.

## Timing
- Reset (asynchronous, takes effect immediately, any cycle including mid-burst):
  - wptr = rptr = count = 0; dout = 0.
  - empty = 1, full = 0, almost_empty = 1 (AE_LEVEL ≥ 0).
  - almost_full = 0 (AF_LEVEL ≥ 1); overflow = underflow = 0.
- Write at edge N:
  - count, empty and full update after edge N.
  - FWFT: the word is on dout after edge N.
  - Standard mode: the earliest read is rd_en sampled at edge N+1, with data on dout after N+1.
- Read latency, standard mode: 1 cycle from rd_en sample to dout.
- Read latency, FWFT: 0 cycles; dout is valid whenever empty = 0.
- Sustained simultaneous read/write at any occupancy 1..DEPTH keeps count constant, with one word per cycle throughput in both directions.
- Flags never glitch relative to clk: all are derived from registers only, never from wr_en or rd_en.

## Structure
- Package sync_fifo_pkg holds:
  - function cnt_width(depth) returning $clog2(depth+1)
  - function ptr_next(ptr, depth) implementing the wrap
- Sub-module sync_fifo_mem holds the storage:
  - DEPTH × DWIDTH array
  - synchronous write port (we, waddr, wdata)
  - asynchronous read port (raddr → rdata)
  - no reset on the array
- sync_fifo_ext owns pointers, count, flags and the output mode.

## Test plan
- DEPTH=4: reset, write 0xA1..0xA4 → full=1, count=4, almost_full=1 at AF_LEVEL=3; fifth write 0xA5 → dropped, overflow=1. Drain in standard mode → dout sequence A1,A2,A3,A4, each one cycle after rd_en.
- DEPTH=5 (non-power-of-two): 12 writes interleaved with reads across two pointer wraps → output order preserved, count never exceeds 5.
- Full FIFO with wr_en=rd_en=1 at the same edge → write accepted, count stays 4, overflow stays 0. Empty FIFO with both asserted → write accepted, count=1, underflow=1.
- FWFT=1: write 0x55 at edge N → after edge N, empty=0 and dout=0x55. rd_en with a second word 0x66 present → dout=0x66 after that edge.
- flush asserted at count=3 together with wr_en → next cycle count=0, empty=1, overflow=underflow=0, write discarded.
- reset asserted between clock edges mid-burst → outputs take reset values immediately. After release, first write/read returns the newly written data.
